// File: rtl/lfsr_prbs_gen_if.sv
// lfsr_prbs_gen_if
//   Groups the control and data signals of the LFSR PRBS generator.
//   master : drives load / seed_in / sam_clk_en, observes the generator outputs
//   slave  : the generator itself
// Signals
//   load        load seed_in into the LFSR state
//   seed_in     runtime seed (WIDTH bits)
//   sam_clk_en  sample-rate strobe, one sys_clk wide
//   out         LFSR state viewed as a two's complement value
//   bit_out     serial PRBS bit (state MSB)
//   cycle       one-clock pulse per completed period
//   lockup      one-clock pulse when an all-zero state is recovered
interface lfsr_prbs_gen_if #(
  parameter int unsigned WIDTH = 22
);
  logic                    load;
  logic [WIDTH-1:0]        seed_in;
  logic                    sam_clk_en;
  logic signed [WIDTH-1:0] out;
  logic                    bit_out;
  logic                    cycle;
  logic                    lockup;

  modport master (
    output load, seed_in, sam_clk_en,
    input  out, bit_out, cycle, lockup
  );

  modport slave (
    input  load, seed_in, sam_clk_en,
    output out, bit_out, cycle, lockup
  );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen
//   Parametrised Fibonacci LFSR pseudo-random generator for DSP test stimulus
//   and noise injection. Steps once per sam_clk_en strobe, accepts a runtime
//   seed, and pulses cycle once every PERIOD steps.
// Ports
//   sys_clk  in  system clock, rising edge
//   reset    in  synchronous, active-high
//   bus      slave side of lfsr_prbs_gen_if (load, seed_in, sam_clk_en in;
//            out, bit_out, cycle, lockup out)
// Build option
//   LFSR_LOCKUP_RECOVER_EN : when defined, a step taken from the all-zero
//   state reloads SEED and pulses lockup; otherwise the zero state is sticky
//   and lockup stays low.
module lfsr_prbs_gen #(
  parameter int unsigned       WIDTH  = 22,
  parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(22'h300000),
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(22'h2FFFFF),
  parameter longint unsigned   PERIOD = (64'd1 << WIDTH) - 64'd1
) (
  input  logic           sys_clk,
  input  logic           reset,
  lfsr_prbs_gen_if.slave bus
);

  // Terminal count for the period counter, truncated to the counter width.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 64'd1);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] cnt;
  logic             cycle_q;
  logic             lockup_q;
  logic             fb;
  logic [WIDTH-1:0] x_step;
  logic             lockup_hit;

  assign fb = ^(x & TAPS);

  always_comb begin
    x_step     = {x[WIDTH-2:0], fb};
    lockup_hit = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    // Zero is a fixed point of the shift; escape it by reseeding.
    if (x == '0) begin
      x_step     = SEED;
      lockup_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      x        <= SEED;
      cnt      <= '0;
      cycle_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else if (bus.load) begin
      // A zero seed would lock the generator, so fall back to SEED.
      x        <= (bus.seed_in != '0) ? bus.seed_in : SEED;
      cnt      <= '0;
      cycle_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else if (bus.sam_clk_en) begin
      x        <= x_step;
      lockup_q <= lockup_hit;
      // Period tracking counts steps, independent of the state value.
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        cycle_q <= 1'b1;
      end else begin
        cnt     <= cnt + 1'b1;
        cycle_q <= 1'b0;
      end
    end else begin
      cycle_q  <= 1'b0;
      lockup_q <= 1'b0;
    end
  end

  assign bus.out     = $signed(x);
  assign bus.bit_out = x[WIDTH-1];
  assign bus.cycle   = cycle_q;
  assign bus.lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen
//   Directed bench for lfsr_prbs_gen. Three instances:
//     a : WIDTH=4, TAPS=C, SEED=F, PERIOD=15 (sequence, spacing, load, reset)
//     b : default 22-bit generator (reset value, first steps, signed view)
//     c : WIDTH=4, TAPS=0, SEED=1 (zero-state behaviour, both build options)
//   Stimulus pushes the expected post-edge state into a scoreboard queue;
//   a monitor on the falling edge pops and compares.
module tb_lfsr_prbs_gen;

  logic       sys_clk;
  logic [2:0] rst_sel;

  lfsr_prbs_gen_if #(.WIDTH(4))  bus_a ();
  lfsr_prbs_gen_if #(.WIDTH(22)) bus_b ();
  lfsr_prbs_gen_if #(.WIDTH(4))  bus_c ();

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'hF), .PERIOD(15)) dut_a (
    .sys_clk(sys_clk), .reset(rst_sel[0]), .bus(bus_a)
  );

  lfsr_prbs_gen dut_b (
    .sys_clk(sys_clk), .reset(rst_sel[1]), .bus(bus_b)
  );

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'h0), .SEED(4'h1), .PERIOD(15)) dut_c (
    .sys_clk(sys_clk), .reset(rst_sel[2]), .bus(bus_c)
  );

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    int unsigned dut;
    logic [31:0] x;
    logic        cyc;
    logic        lck;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Full period of the 4-bit generator starting from F.
  logic [3:0] P [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                         4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  function automatic logic [31:0] sext(logic [31:0] v, int w);
    logic [31:0] r;
    r = v;
    for (int i = w; i < 32; i++) r[i] = v[w-1];
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(negedge sys_clk) begin
    exp_t        e;
    logic [31:0] ax;
    logic [31:0] as;
    logic        ab;
    logic        ac;
    logic        al;
    int          w;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin
          ax = {28'b0, $unsigned(bus_a.out)}; as = int'(bus_a.out);
          ab = bus_a.bit_out; ac = bus_a.cycle; al = bus_a.lockup; w = 4;
        end
        1: begin
          ax = {10'b0, $unsigned(bus_b.out)}; as = int'(bus_b.out);
          ab = bus_b.bit_out; ac = bus_b.cycle; al = bus_b.lockup; w = 22;
        end
        default: begin
          ax = {28'b0, $unsigned(bus_c.out)}; as = int'(bus_c.out);
          ab = bus_c.bit_out; ac = bus_c.cycle; al = bus_c.lockup; w = 4;
        end
      endcase
      chk({e.name, ".x"},      ax, e.x);
      chk({e.name, ".signed"}, as, sext(e.x, w));
      chk({e.name, ".bit"},    {31'b0, ab}, {31'b0, e.x[w-1]});
      chk({e.name, ".cycle"},  {31'b0, ac}, {31'b0, e.cyc});
      chk({e.name, ".lockup"}, {31'b0, al}, {31'b0, e.lck});
    end
  end

  // One clock of stimulus on one instance; entered and left just after a
  // falling edge. The expectation is queued right after the rising edge.
  task automatic tick(int unsigned d, bit rst, bit ld, logic [31:0] seed,
                      bit en, logic [31:0] ex, bit ec, bit el, string n);
    exp_t e;
    case (d)
      0: begin
        rst_sel[0] = rst; bus_a.load = ld; bus_a.seed_in = seed[3:0]; bus_a.sam_clk_en = en;
      end
      1: begin
        rst_sel[1] = rst; bus_b.load = ld; bus_b.seed_in = seed[21:0]; bus_b.sam_clk_en = en;
      end
      default: begin
        rst_sel[2] = rst; bus_c.load = ld; bus_c.seed_in = seed[3:0]; bus_c.sam_clk_en = en;
      end
    endcase
    @(posedge sys_clk);
    e.dut = d; e.x = ex; e.cyc = ec; e.lck = el; e.name = n;
    sb.push_back(e);
    @(negedge sys_clk);
    rst_sel = '0;
    bus_a.load = 1'b0; bus_a.sam_clk_en = 1'b0;
    bus_b.load = 1'b0; bus_b.sam_clk_en = 1'b0;
    bus_c.load = 1'b0; bus_c.sam_clk_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_sel = '0;
    bus_a.load = 1'b0; bus_a.seed_in = '0; bus_a.sam_clk_en = 1'b0;
    bus_b.load = 1'b0; bus_b.seed_in = '0; bus_b.sam_clk_en = 1'b0;
    bus_c.load = 1'b0; bus_c.seed_in = '0; bus_c.sam_clk_en = 1'b0;
    @(negedge sys_clk);

    // T1: reset then 16 back-to-back strobes.
    tick(0, 1, 0, 0, 0, {28'b0, P[0]}, 0, 0, "t1_reset");
    for (int i = 1; i <= 16; i++)
      tick(0, 0, 0, 0, 1, {28'b0, P[i % 15]}, (i == 15), 0, "t1_step");

    // T2: strobes alternately 7 clocks and 1 clock apart.
    tick(0, 1, 0, 0, 0, {28'b0, P[0]}, 0, 0, "t2_reset");
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0, 0, 1, {28'b0, P[i % 15]}, (i == 15), 0, "t2_step");
      if (i % 2 == 0)
        for (int g = 0; g < 6; g++)
          tick(0, 0, 0, 0, 0, {28'b0, P[i % 15]}, 0, 0, "t2_hold");
    end

    // T3: load with a coincident strobe, then a full period from the seed.
    tick(0, 1, 0, 0, 0, {28'b0, P[0]}, 0, 0, "t3_reset");
    for (int i = 1; i <= 3; i++)
      tick(0, 0, 0, 0, 1, {28'b0, P[i]}, 0, 0, "t3_pre");
    tick(0, 0, 1, 32'h9, 1, 32'h9, 0, 0, "t3_load");
    for (int k = 1; k <= 15; k++)
      tick(0, 0, 0, 0, 1, {28'b0, P[(7 + k) % 15]}, (k == 15), 0, "t3_step");

    // T4: zero-seed load falls back to SEED; reset mid-period restarts count.
    for (int i = 1; i <= 3; i++)
      tick(0, 0, 0, 0, 1, {28'b0, P[(7 + i) % 15]}, 0, 0, "t4_pre");
    tick(0, 0, 1, 32'h0, 0, {28'b0, P[0]}, 0, 0, "t4_load0");
    for (int i = 1; i <= 7; i++)
      tick(0, 0, 0, 0, 1, {28'b0, P[i]}, 0, 0, "t4_mid");
    tick(0, 1, 0, 0, 1, {28'b0, P[0]}, 0, 0, "t4_reset_mid");
    for (int i = 1; i <= 15; i++)
      tick(0, 0, 0, 0, 1, {28'b0, P[i % 15]}, (i == 15), 0, "t4_step");

    // T5: zero state with a degenerate tap mask.
    tick(2, 1, 0, 0, 0, 32'h1, 0, 0, "t5_reset");
    tick(2, 0, 0, 0, 1, 32'h2, 0, 0, "t5_s1");
    tick(2, 0, 0, 0, 1, 32'h4, 0, 0, "t5_s2");
    tick(2, 0, 0, 0, 1, 32'h8, 0, 0, "t5_s3");
    tick(2, 0, 0, 0, 1, 32'h0, 0, 0, "t5_s4");
    tick(2, 0, 0, 0, 1, RECOVER ? 32'h1 : 32'h0, 0, RECOVER, "t5_s5");
    tick(2, 0, 0, 0, 1, RECOVER ? 32'h2 : 32'h0, 0, 0, "t5_s6");

    // T6 (shortened): default 22-bit generator.
    tick(1, 1, 0, 0, 0, 32'h2FFFFF, 0, 0, "t6_reset");
    tick(1, 0, 0, 0, 1, 32'h1FFFFF, 0, 0, "t6_s1");
    tick(1, 0, 0, 0, 0, 32'h1FFFFF, 0, 0, "t6_hold");
    tick(1, 0, 0, 0, 1, 32'h3FFFFF, 0, 0, "t6_s2");
    tick(1, 0, 0, 0, 1, 32'h3FFFFE, 0, 0, "t6_s3");
    tick(1, 0, 1, 32'h1, 1, 32'h1, 0, 0, "t6_load");
    tick(1, 0, 0, 0, 1, 32'h2, 0, 0, "t6_s4");
    tick(1, 0, 1, 32'h0, 0, 32'h2FFFFF, 0, 0, "t6_load0");

    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
